// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the ALU bus sequencer.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_FEED,
    S_WAIT,
    S_DONE
  } seq_state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // Result reported when the ALU never signals END.
  localparam logic [15:0] TIMEOUT_RESULT = 16'hFFFF;

  // Divide needs a divisor byte on top of the two dividend bytes.
  function automatic logic [1:0] nbytes_for_op(input logic [1:0] op);
    return (op == OP_DIV) ? 2'd3 : 2'd2;
  endfunction

endpackage

// File: rtl/alu_result_capture.sv
// alu_result_capture: two-deep history of the ALU outbus. Entries that were
// never sampled since the last clear read back as zero.
module alu_result_capture #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                shift_en,
  input  logic [DATA_W-1:0]   din,
  output logic [2*DATA_W-1:0] word
);

  logic [DATA_W-1:0] hist1_q;
  logic [DATA_W-1:0] hist0_q;
  logic [1:0]        cnt_q;

  // Shift register plus saturating count of valid samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist1_q <= '0;
      hist0_q <= '0;
      cnt_q   <= 2'd0;
    end else if (clear) begin
      hist1_q <= '0;
      hist0_q <= '0;
      cnt_q   <= 2'd0;
    end else if (shift_en) begin
      hist1_q <= hist0_q;
      hist0_q <= din;
      if (cnt_q != 2'd2) cnt_q <= cnt_q + 2'd1;
    end
  end

  assign word = {(cnt_q == 2'd2) ? hist1_q : {DATA_W{1'b0}},
                 (cnt_q != 2'd0) ? hist0_q : {DATA_W{1'b0}}};

endmodule

// File: rtl/alu_bus_sequencer.sv
// alu_bus_sequencer: turns one request into the ALU's BEGIN / operand-stream /
// END protocol and returns the 16-bit result over a valid/ready handshake.
// Optional END watchdog: define ALU_SEQ_WDOG_EN.
//
// state   | meaning
// S_IDLE  | waiting for a request (req_ready high)
// S_START | one-cycle BEGIN pulse
// S_FEED  | one operand byte per cycle on alu_inbus
// S_WAIT  | waiting for alu_end (or watchdog expiry)
// S_DONE  | result presented until rsp_ready
module alu_bus_sequencer
  import alu_seq_pkg::*;
#(
  parameter int MAX_WAIT = 64,
  parameter int DATA_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [DATA_W-1:0]   req_b0,
  input  logic [DATA_W-1:0]   req_b1,
  input  logic [DATA_W-1:0]   req_b2,
  output logic                alu_begin,
  output logic [1:0]          alu_op_code,
  output logic [DATA_W-1:0]   alu_inbus,
  input  logic [DATA_W-1:0]   alu_outbus,
  input  logic                alu_end,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [2*DATA_W-1:0] rsp_data,
  output logic                rsp_err
);

  seq_state_e          state_q, state_d;
  logic                started_q;
  logic [1:0]          idx_q, idx_d;
  logic [1:0]          op_q;
  logic [1:0]          nbytes_q;
  logic [DATA_W-1:0]   byte0_q, byte1_q, byte2_q;
  logic [2*DATA_W-1:0] rsp_data_q;
  logic                rsp_err_q;
  logic [2*DATA_W-1:0] cap_word;
  logic                load_req, load_rsp, err_d, timeout, shift_en;

`ifdef ALU_SEQ_WDOG_EN
  localparam int WCNT_W = $clog2(MAX_WAIT + 1);
  logic [WCNT_W-1:0] wait_cnt_q;

  // Held at zero outside WAIT, so it is already clear on WAIT entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 wait_cnt_q <= '0;
    else if (state_q != S_WAIT) wait_cnt_q <= '0;
    else                        wait_cnt_q <= wait_cnt_q + 1'b1;
  end
`else
  logic unused_max_wait;
  assign unused_max_wait = (MAX_WAIT > 0);
`endif

  alu_result_capture #(.DATA_W(DATA_W)) u_capture (
    .clk      (clk),
    .reset    (reset),
    .clear    (load_req),
    .shift_en (shift_en),
    .din      (alu_outbus),
    .word     (cap_word)
  );

  // Next-state and per-state outputs.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    alu_begin = 1'b0;
    alu_inbus = '0;
    load_req  = 1'b0;
    load_rsp  = 1'b0;
    err_d     = 1'b0;
    timeout   = 1'b0;
    shift_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          load_req = 1'b1;
          state_d  = S_START;
        end
      end
      S_START: begin
        alu_begin = 1'b1;
        idx_d     = 2'd0;
        if (alu_end) begin
          load_rsp = 1'b1;
          err_d    = 1'b1;
          state_d  = S_DONE;
        end else begin
          state_d = S_FEED;
        end
      end
      S_FEED: begin
        alu_inbus = (idx_q == 2'd0) ? byte0_q :
                    (idx_q == 2'd1) ? byte1_q : byte2_q;
        shift_en  = 1'b1;
        if (alu_end) begin
          load_rsp = 1'b1;
          err_d    = 1'b1;
          state_d  = S_DONE;
        end else begin
          idx_d = idx_q + 2'd1;
          if (idx_q == nbytes_q - 2'd1) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        shift_en = 1'b1;
        if (alu_end) begin
          load_rsp = 1'b1;
          state_d  = S_DONE;
        end
`ifdef ALU_SEQ_WDOG_EN
        // This WAIT cycle brings the count to MAX_WAIT; END above wins.
        else if (wait_cnt_q == WCNT_W'(MAX_WAIT - 1)) begin
          load_rsp = 1'b1;
          err_d    = 1'b1;
          timeout  = 1'b1;
          state_d  = S_DONE;
        end
`endif
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; started_q keeps req_ready low until the first clock after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      started_q <= 1'b0;
      idx_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      idx_q     <= idx_d;
    end
  end

  // Request latch, loaded on acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q     <= OP_ADD;
      nbytes_q <= 2'd0;
      byte0_q  <= '0;
      byte1_q  <= '0;
      byte2_q  <= '0;
    end else if (load_req) begin
      op_q     <= req_op;
      nbytes_q <= nbytes_for_op(req_op);
      byte0_q  <= req_b0;
      byte1_q  <= req_b1;
      byte2_q  <= req_b2;
    end
  end

  // Response register, held until the next result loads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else if (load_rsp) begin
      rsp_data_q <= timeout ? (2*DATA_W)'(TIMEOUT_RESULT) : cap_word;
      rsp_err_q  <= err_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE) && started_q;
  assign alu_op_code = (state_q == S_IDLE) ? OP_ADD : op_q;
  assign rsp_valid   = (state_q == S_DONE);
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_alu_bus_sequencer.sv
// tb_alu_bus_sequencer: scoreboard bench; expected responses are queued when a
// request is issued and popped when the response handshake completes.
module tb_alu_bus_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [7:0]  req_b0 = 8'h00, req_b1 = 8'h00, req_b2 = 8'h00;
  logic        alu_begin;
  logic [1:0]  alu_op_code;
  logic [7:0]  alu_inbus;
  logic [7:0]  alu_outbus = 8'h00;
  logic        alu_end = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_err;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          lat;
  int          k;
  logic [16:0] exp_q[$];

  alu_bus_sequencer #(.MAX_WAIT(8), .DATA_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_b0      (req_b0),
    .req_b1      (req_b1),
    .req_b2      (req_b2),
    .alu_begin   (alu_begin),
    .alu_op_code (alu_op_code),
    .alu_inbus   (alu_inbus),
    .alu_outbus  (alu_outbus),
    .alu_end     (alu_end),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_begin", alu_begin, 0);
    chk("rst_op_code", alu_op_code, 0);
    chk("rst_inbus", alu_inbus, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    chk("req_ready_wait", req_ready, 1);
  endtask

  // Issue a request and walk START plus FEED; outbus carries A0+i while feeding.
  // Returns in the last FEED cycle, or in DONE when END is forced at FEED index 'early'.
  task automatic send_and_feed(input logic [1:0] op, input logic [7:0] b0, b1, b2,
                               input int early, output int lat_o);
    logic [7:0] bytes[3];
    int nb;
    bytes[0] = b0;
    bytes[1] = b1;
    bytes[2] = b2;
    nb = (op == 2'b11) ? 3 : 2;
    wait_ready();
    req_op = op; req_b0 = b0; req_b1 = b1; req_b2 = b2;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    lat_o = 1;
    chk("begin_pulse", alu_begin, 1);
    chk("op_code", alu_op_code, op);
    chk("inbus_start", alu_inbus, 0);
    for (int i = 0; i < nb; i++) begin
      tick();
      lat_o++;
      chk("inbus_feed", alu_inbus, bytes[i]);
      chk("begin_low", alu_begin, 0);
      chk("op_held", alu_op_code, op);
      alu_outbus = 8'hA0 + 8'(i);
      if (i == early) begin
        alu_end = 1'b1;
        tick();
        lat_o++;
        alu_end = 1'b0;
        alu_outbus = 8'h00;
        chk("inbus_after_early", alu_inbus, 0);
        chk("early_valid", rsp_valid, 1);
        break;
      end
    end
  endtask

  // ALU model: high byte, low byte, then END.
  task automatic alu_respond(input logic [7:0] hi, lo, inout int lat_io);
    tick(); lat_io++; alu_outbus = hi;
    tick(); lat_io++; alu_outbus = lo;
    tick(); lat_io++; alu_outbus = 8'h00; alu_end = 1'b1;
    tick(); lat_io++; alu_end = 1'b0;
    chk("rsp_valid", rsp_valid, 1);
  endtask

  // Hold rsp_ready low for bp cycles (poking req_valid and alu_end), then accept.
  task automatic take_rsp(input int bp);
    logic [15:0] d0;
    logic        e0;
    logic [16:0] exp;
    d0 = rsp_data;
    e0 = rsp_err;
    exp = '0;
    for (int i = 0; i < bp; i++) begin
      rsp_ready = 1'b0;
      req_valid = (i == 2);
      alu_end   = (i == 4);
      tick();
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data_stable", rsp_data, d0);
      chk("bp_err_stable", rsp_err, e0);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_begin", alu_begin, 0);
    end
    req_valid = 1'b0;
    alu_end   = 1'b0;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      exp = exp_q.pop_front();
      chk("rsp_data", rsp_data, exp[15:0]);
      chk("rsp_err", rsp_err, exp[16]);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("valid_drop", rsp_valid, 0);
    chk("ready_back", req_ready, 1);
    chk("data_held", rsp_data, exp[15:0]);
  endtask

  task automatic reset_in_wait();
    reset = 1'b0;
    #2;
    chk_reset_vals();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #2;
    chk_reset_vals();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("ready_before_clk", req_ready, 0);
    tick();
    chk("ready_first_clk", req_ready, 1);

    // add 12+34
    exp_q.push_back({1'b0, 16'h0046});
    send_and_feed(2'b00, 8'h12, 8'h34, 8'h00, -1, lat);
    alu_respond(8'h00, 8'h46, lat);
    chk("lat_add", lat, 7);
    take_rsp(0);

    // divide 0x0064 / 7, with backpressure
    exp_q.push_back({1'b0, 16'h020E});
    send_and_feed(2'b11, 8'h00, 8'h64, 8'h07, -1, lat);
    alu_respond(8'h02, 8'h0E, lat);
    chk("lat_div", lat, 8);
    take_rsp(10);
    chk("idle_no_begin", alu_begin, 0);

    // sub, back-to-back
    exp_q.push_back({1'b0, 16'h0040});
    send_and_feed(2'b01, 8'h50, 8'h10, 8'hFF, -1, lat);
    alu_respond(8'h00, 8'h40, lat);
    take_rsp(1);

    // mul with END in the second FEED cycle: one sample (A0) captured
    exp_q.push_back({1'b1, 16'h00A0});
    send_and_feed(2'b10, 8'h03, 8'h04, 8'h00, 1, lat);
    take_rsp(0);

    // ALU never ends
`ifdef ALU_SEQ_WDOG_EN
    exp_q.push_back({1'b1, 16'hFFFF});
`endif
    send_and_feed(2'b10, 8'h05, 8'h06, 8'h00, -1, lat);
    tick();
    alu_outbus = 8'h00;
    k = 0;
`ifdef ALU_SEQ_WDOG_EN
    while (!rsp_valid && k < 40) begin
      tick();
      k++;
    end
    chk("wdog_cycles", k, 8);
    take_rsp(0);
`else
    while (!rsp_valid && k < 40) begin
      tick();
      k++;
    end
    chk("no_timeout_valid", rsp_valid, 0);
    reset_in_wait();
`endif

    // reset during WAIT, then a normal transaction
    send_and_feed(2'b00, 8'h01, 8'h02, 8'h00, -1, lat);
    tick();
    tick();
    tick();
    reset_in_wait();
    exp_q.push_back({1'b0, 16'h0003});
    send_and_feed(2'b00, 8'h01, 8'h02, 8'h00, -1, lat);
    alu_respond(8'h00, 8'h03, lat);
    take_rsp(0);

    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
